// File: rtl/bus_sram_responder.sv
// Bus responder: word-wide synchronous RAM behind a programmable wait-state sequencer.
// Each access stalls the initiator for WAIT_STATES cycles. It then completes only if the live
// request still matches the request that was latched when the access started.
module bus_sram_responder #(
    parameter int unsigned ADDR_WORDS_LOG2 = 12,
    parameter int unsigned WAIT_STATES     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] busaddr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
    input  logic [2:0]  data_size,
    output logic        rw_wait,
    output logic [31:0] rd_data,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int unsigned AW    = ADDR_WORDS_LOG2;
    localparam int unsigned Depth = 1 << AW;
    // Value of the wait counter in the last WAIT cycle before READY.
    localparam logic [3:0] WaitLast = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   lat_addr_q, lat_addr_d;
    logic            lat_rnw_q, lat_rnw_d;
    logic [2:0]      lat_size_q, lat_size_d;
    logic [1:0]      lat_off_q, lat_off_d;
    logic [15:0]     rd_count_q, rd_count_d;
    logic [15:0]     wr_count_q, wr_count_d;
    logic [31:0]     rd_data_q;

    logic [31:0]     mem [Depth];

    logic            req;
    logic            req_rnw;
    logic [AW-1:0]   req_idx;
    logic            match;
    logic            rw_wait_c;
    logic            commit_wr;
    logic            load_rd;
    logic [AW-1:0]   rd_idx;
    logic [3:0]      byte_en;
    logic            unused_busaddr;

    // Simultaneous rd_req and wr_req is a read; the write side is ignored.
    assign req     = rd_req | wr_req;
    assign req_rnw = rd_req;
    assign req_idx = busaddr[AW+1:2];
    assign match   = req && (req_idx == lat_addr_q) && (req_rnw == lat_rnw_q)
                     && (data_size == lat_size_q);

    // Address bits above the RAM range alias.
    assign unused_busaddr = ^busaddr[31:AW+2];

    // Byte lanes for the latched write; unknown sizes write nothing.
    always_comb begin
        byte_en = 4'b0000;
        case (lat_size_q)
            3'b001:  byte_en = 4'b0001 << lat_off_q;
            3'b010:  byte_en = lat_off_q[1] ? 4'b1100 : 4'b0011;
            3'b100:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Next-state, latch, counter and stall logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        lat_rnw_d  = lat_rnw_q;
        lat_size_d = lat_size_q;
        lat_off_d  = lat_off_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        rw_wait_c  = 1'b0;
        commit_wr  = 1'b0;
        load_rd    = 1'b0;
        rd_idx     = lat_addr_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    rw_wait_c  = 1'b1;
                    lat_addr_d = req_idx;
                    lat_rnw_d  = req_rnw;
                    lat_size_d = data_size;
                    lat_off_d  = busaddr[1:0];
                    cnt_d      = 4'd1;
                    if (WAIT_STATES == 1) begin
                        // The latch is not visible yet, so read the live address.
                        state_d = StReady;
                        load_rd = req_rnw;
                        rd_idx  = req_idx;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                rw_wait_c = 1'b1;
                if (!match) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == WaitLast) begin
                    state_d = StReady;
                    load_rd = lat_rnw_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StReady: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
                if (match) begin
                    rw_wait_c = 1'b0;
                    if (lat_rnw_q) begin
                        rd_count_d = rd_count_q + 16'd1;
                    end else begin
                        wr_count_d = wr_count_q + 16'd1;
                        commit_wr  = 1'b1;
                    end
                end else begin
                    rw_wait_c = req;
                end
            end
            default: state_d = StIdle;
        endcase

        // While reset is held, any request is stalled.
        if (rst) begin
            rw_wait_c = req;
            commit_wr = 1'b0;
            load_rd   = 1'b0;
        end
    end

    // Sequencer state and counters, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            lat_addr_q <= '0;
            lat_rnw_q  <= 1'b0;
            lat_size_q <= 3'b000;
            lat_off_q  <= 2'b00;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            lat_rnw_q  <= lat_rnw_d;
            lat_size_q <= lat_size_d;
            lat_off_q  <= lat_off_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // RAM write port with per-byte lane enables; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[lat_addr_q][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Registered RAM read, loaded on the edge entering READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 32'h0;
        end else if (load_rd) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rw_wait  = rw_wait_c;
    assign rd_data  = rd_data_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench: one responder with a single wait state and one with four,
// both checked against a word-array memory model and counter model.
module tb_bus_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req, wr_req, sel;
    logic [31:0] busaddr, wr_data;
    logic [2:0]  data_size;

    logic        rw_wait1, rw_wait4;
    logic [31:0] rd_data1, rd_data4;
    logic [15:0] rdc1, wrc1, rdc4, wrc4;

    logic        rw_wait_s;
    logic [31:0] rd_data_s;
    logic [15:0] rdc_s, wrc_s;

    int          total = 0;
    int          passed = 0;
    int          exp_rd [2];
    int          exp_wr [2];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    bus_sram_responder #(.ADDR_WORDS_LOG2(12), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .busaddr(busaddr),
        .rd_req(rd_req & ~sel), .wr_req(wr_req & ~sel),
        .wr_data(wr_data), .data_size(data_size),
        .rw_wait(rw_wait1), .rd_data(rd_data1), .rd_count(rdc1), .wr_count(wrc1)
    );

    bus_sram_responder #(.ADDR_WORDS_LOG2(12), .WAIT_STATES(4)) dut4 (
        .clk(clk), .rst(rst), .busaddr(busaddr),
        .rd_req(rd_req & sel), .wr_req(wr_req & sel),
        .wr_data(wr_data), .data_size(data_size),
        .rw_wait(rw_wait4), .rd_data(rd_data4), .rd_count(rdc4), .wr_count(wrc4)
    );

    assign rw_wait_s = sel ? rw_wait4 : rw_wait1;
    assign rd_data_s = sel ? rd_data4 : rd_data1;
    assign rdc_s     = sel ? rdc4 : rdc1;
    assign wrc_s     = sel ? wrc4 : wrc1;

    function automatic int mkey(input logic s, input logic [31:0] a);
        return (int'(s) << 12) | int'(a[13:2]);
    endfunction

    // Reference write: select the lanes the size/offset names, leave the rest.
    function automatic void model_write(input int k, input logic [31:0] a,
                                        input logic [31:0] d, input logic [2:0] sz);
        logic [31:0] w;
        w = mdl.exists(k) ? mdl[k] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if ((sz == 3'b100) || (sz == 3'b010 && (b / 2) == int'(a[1]))
                || (sz == 3'b001 && b == int'(a[1:0]))) begin
                w[8*b +: 8] = d[8*b +: 8];
            end
        end
        mdl[k] = w;
    endfunction

    // Drives one access on the selected responder; called just after a posedge,
    // returns just after the posedge ending the completion cycle.
    task automatic do_access(input bit rnw, input bit both, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] size,
                             output logic [31:0] rdata, output int waits);
        bit done;
        busaddr   = addr;
        wr_data   = data;
        data_size = size;
        rd_req    = rnw | both;
        wr_req    = !rnw | both;
        waits     = 0;
        done      = 1'b0;
        rdata     = 32'hx;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (rw_wait_s) waits++;
            else begin
                done  = 1'b1;
                rdata = rd_data_s;
            end
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL access_timeout addr=%h waits=%0d required completion in 40", addr,
                     waits);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rd[0] = 0; exp_wr[0] = 0; exp_rd[1] = 0; exp_wr[1] = 0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        busaddr = 32'h0; wr_data = 32'h0; data_size = 3'b100;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rw_wait1, rw_wait4} !== 2'b00)
            $display("FAIL reset_rw_wait got=%b want=00", {rw_wait1, rw_wait4});
        else passed++;
        total++;
        if ({rd_data1, rd_data4} !== 64'h0)
            $display("FAIL reset_rd_data got=%h/%h want=0", rd_data1, rd_data4);
        else passed++;
        total++;
        if ({rdc1, wrc1, rdc4, wrc4} !== 64'h0)
            $display("FAIL reset_counts got=%h want=0", {rdc1, wrc1, rdc4, wrc4});
        else passed++;
        rd_req = 1'b1;
        #1;
        total++;
        if (rw_wait1 !== 1'b1) $display("FAIL reset_req_stall got=%b want=1", rw_wait1);
        else passed++;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rd[0] = 0; exp_wr[0] = 0; exp_rd[1] = 0; exp_wr[1] = 0;
    endtask

    task automatic test_single_wait();
        logic [31:0] rd;
        int w;
        sel = 1'b0;
        do_access(1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 3'b100, rd, w);
        model_write(mkey(1'b0, 32'h100), 32'h100, 32'hDEADBEEF, 3'b100);
        total++;
        if (w !== 1) $display("FAIL ws1_write_waits got=%0d want=1", w); else passed++;
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b100, rd, w);
        total++;
        if (w !== 1) $display("FAIL ws1_read_waits got=%0d want=1", w); else passed++;
        total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL ws1_read_data got=%h want=deadbeef", rd);
        else passed++;
        total++;
        if ({rdc_s, wrc_s} !== {16'd1, 16'd1})
            $display("FAIL ws1_counts got=%0d/%0d want=1/1", rdc_s, wrc_s);
        else passed++;
        exp_rd[0] = 1; exp_wr[0] = 1;
    endtask

    task automatic test_lanes();
        logic [31:0] rd;
        int w;
        sel = 1'b0;
        do_access(1'b0, 1'b0, 32'h103, 32'h5A5A5A5A, 3'b001, rd, w);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b100, rd, w);
        total++;
        if (rd !== 32'h5AADBEEF) $display("FAIL byte_lane got=%h want=5aadbeef", rd);
        else passed++;
        do_access(1'b0, 1'b0, 32'h102, 32'h12341234, 3'b010, rd, w);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b001, rd, w);
        total++;
        if (rd !== 32'h1234BEEF) $display("FAIL half_lane got=%h want=1234beef", rd);
        else passed++;
        mdl[mkey(1'b0, 32'h100)] = 32'h1234BEEF;
        exp_rd[0] += 2; exp_wr[0] += 2;
    endtask

    task automatic test_bad_size();
        logic [31:0] rd;
        int w;
        sel = 1'b0;
        do_access(1'b0, 1'b0, 32'h10, 32'hCAFEF00D, 3'b100, rd, w);
        do_access(1'b0, 1'b0, 32'h10, 32'h11111111, 3'b011, rd, w);
        exp_wr[0] += 2;
        total++;
        if (w !== 1) $display("FAIL bad_size_waits got=%0d want=1", w); else passed++;
        total++;
        if (int'(wrc_s) !== exp_wr[0])
            $display("FAIL bad_size_wr_count got=%0d want=%0d", wrc_s, exp_wr[0]);
        else passed++;
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b100, rd, w);
        exp_rd[0] += 1;
        total++;
        if (rd !== 32'hCAFEF00D) $display("FAIL bad_size_data got=%h want=cafef00d", rd);
        else passed++;
        mdl[mkey(1'b0, 32'h10)] = 32'hCAFEF00D;
    endtask

    task automatic test_four_wait();
        logic [31:0] rd;
        int w;
        sel = 1'b1;
        do_access(1'b0, 1'b0, 32'h40, 32'hA5A50F0F, 3'b100, rd, w);
        total++;
        if (w !== 4) $display("FAIL ws4_write_waits got=%0d want=4", w); else passed++;
        // The read starts in the cycle right after the write completes.
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 3'b100, rd, w);
        total++;
        if (w !== 4) $display("FAIL ws4_read_waits got=%0d want=4", w); else passed++;
        total++;
        if (rd !== 32'hA5A50F0F) $display("FAIL ws4_read_data got=%h want=a5a50f0f", rd);
        else passed++;
        @(negedge clk);
        total++;
        if (rw_wait_s !== 1'b0) $display("FAIL ws4_idle_after got=%b want=0", rw_wait_s);
        else passed++;
        @(posedge clk);
        #1;
        mdl[mkey(1'b1, 32'h40)] = 32'hA5A50F0F;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int w;
        sel = 1'b1;
        do_reset();
        busaddr = 32'h40; data_size = 3'b100; rd_req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b0, 32'h44, 32'h0BADF00D, 3'b100, rd, w);
        total++;
        if (w !== 4) $display("FAIL abort_fresh_waits got=%0d want=4", w); else passed++;
        total++;
        if ({rdc_s, wrc_s} !== {16'd0, 16'd1})
            $display("FAIL abort_counts got=%0d/%0d want=0/1", rdc_s, wrc_s);
        else passed++;
        exp_wr[1] = 1;
        mdl[mkey(1'b1, 32'h44)] = 32'h0BADF00D;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int w;
        sel = 1'b1;
        do_access(1'b0, 1'b0, 32'h80, 32'h13579BDF, 3'b100, rd, w);
        busaddr = 32'h80; wr_data = 32'hFFFFFFFF; data_size = 3'b100; wr_req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        wr_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rd[0] = 0; exp_wr[0] = 0; exp_rd[1] = 0; exp_wr[1] = 0;
        total++;
        if ({rdc4, wrc4} !== 32'h0)
            $display("FAIL rst_mid_counts got=%0d/%0d want=0/0", rdc4, wrc4);
        else passed++;
        do_access(1'b1, 1'b0, 32'h80, 32'h0, 3'b100, rd, w);
        total++;
        if (rd !== 32'h13579BDF) $display("FAIL rst_mid_data got=%h want=13579bdf", rd);
        else passed++;
        total++;
        if (w !== 4 || rdc4 !== 16'd1)
            $display("FAIL rst_mid_restart waits=%0d rd_count=%0d want 4/1", w, rdc4);
        else passed++;
        exp_rd[1] = 1;
        mdl[mkey(1'b1, 32'h80)] = 32'h13579BDF;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, expv;
        logic [2:0]  sz;
        int w, errs;
        bit rnw, both, s;
        logic [2:0] sizes [4];
        sizes[0] = 3'b001; sizes[1] = 3'b010; sizes[2] = 3'b100; sizes[3] = 3'b011;
        for (int i = 0; i < 32; i++) begin
            sel = i[4];
            a = 32'h200 + 32'(i[3:0]) * 4;
            d = $urandom;
            do_access(1'b0, 1'b0, a, d, 3'b100, rd, w);
            model_write(mkey(sel, a), a, d, 3'b100);
            exp_wr[sel]++;
        end
        errs = 0;
        for (int i = 0; i < 80; i++) begin
            s    = 1'($urandom_range(0, 1));
            rnw  = 1'($urandom_range(0, 1));
            both = ($urandom_range(0, 7) == 0);
            a    = 32'h200 + 32'($urandom_range(0, 63));
            // Aliased upper bits must not matter.
            a[31:16] = 16'($urandom);
            d    = $urandom;
            sz   = sizes[$urandom_range(0, 3)];
            sel  = s;
            do_access(rnw, both, a, d, sz, rd, w);
            if (w !== (s ? 4 : 1)) begin
                errs++;
                $display("FAIL rand_waits op=%0d got=%0d want=%0d", i, w, s ? 4 : 1);
            end
            if (rnw || both) begin
                expv = mdl[mkey(s, a)];
                exp_rd[s]++;
                if (rd !== expv) begin
                    errs++;
                    $display("FAIL rand_read op=%0d addr=%h got=%h want=%h", i, a, rd, expv);
                end
            end else begin
                model_write(mkey(s, a), a, d, sz);
                exp_wr[s]++;
            end
        end
        total++;
        if (errs != 0) $display("FAIL rand_ops errors=%0d want=0", errs); else passed++;
        total++;
        if ({int'(rdc1), int'(wrc1), int'(rdc4), int'(wrc4)}
            !== {exp_rd[0], exp_wr[0], exp_rd[1], exp_wr[1]})
            $display("FAIL rand_counts got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", rdc1, wrc1,
                     rdc4, wrc4, exp_rd[0], exp_wr[0], exp_rd[1], exp_wr[1]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_wait();
        test_lanes();
        test_bad_size();
        test_four_wait();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
